elastic_stream_src: RTL and testbench

- Initiator-side traffic source for the valid/ready elastic stages.
- Drives a counted burst of data beats onto an initiator (i_*) interface.
- Honours downstream backpressure, inserts a programmable idle gap between beats, and reports completion.
- Used in front of elastic stages and at subsystem inputs to generate directed, repeatable streams.

---
 rtl/elastic_stream_src_if.sv | 11 +
 rtl/elastic_stream_src.sv | 121 ++++++++++++
 tb/tb_elastic_stream_src.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/elastic_stream_src_if.sv
// rtl/elastic_stream_src_if.sv - initiator-side valid/ready stream bundle
interface elastic_stream_src_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              i_ready;

    modport master (output i_data, output i_valid, input i_ready);
    modport slave  (input i_data, input i_valid, output i_ready);
endinterface

// File: rtl/elastic_stream_src.sv
// rtl/elastic_stream_src.sv - counted-burst valid/ready traffic source with idle gaps
// Optional: ELASTIC_SRC_LFSR_EN switches the data advance from +1 to a Galois LFSR.
module elastic_stream_src #(
    parameter int                DATA_W    = 32,
    parameter int                CNT_W     = 16,
    parameter int                GAP_W     = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 32'h80200003
) (
    input  logic                 clk,
    input  logic                 rstf,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_xfers,
    input  logic [GAP_W-1:0]     gap_cycles,
    input  logic [DATA_W-1:0]    seed,
    elastic_stream_src_if.master stream,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     xfer_count
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              valid_q, valid_n;
    logic [CNT_W-1:0]  remaining, remaining_n;
    logic [CNT_W-1:0]  count_n;
    logic [GAP_W-1:0]  gap_lat, gap_lat_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic [DATA_W-1:0] seed_eff;
    logic [DATA_W-1:0] data_adv;

`ifdef ELASTIC_SRC_LFSR_EN
    // An all-zero Galois state never leaves zero, so a zero seed is promoted to 1.
    assign seed_eff = (seed == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : seed;
    assign data_adv = (data_q >> 1) ^ (data_q[0] ? LFSR_TAPS : '0);
`else
    assign seed_eff = seed;
    assign data_adv = data_q + DATA_W'(1);
`endif

    always_comb begin
        state_n     = state;
        data_n      = data_q;
        valid_n     = valid_q;
        remaining_n = remaining;
        count_n     = xfer_count;
        gap_lat_n   = gap_lat;
        gap_cnt_n   = gap_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    count_n = '0;
                    if (num_xfers != '0) begin
                        state_n     = SEND;
                        remaining_n = num_xfers;
                        gap_lat_n   = gap_cycles;
                        data_n      = seed_eff;
                        valid_n     = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SEND: begin
                if (valid_q && stream.i_ready) begin
                    count_n     = xfer_count + CNT_W'(1);
                    remaining_n = remaining - CNT_W'(1);
                    data_n      = data_adv;
                    if (remaining == CNT_W'(1)) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                    end else if (gap_lat != '0) begin
                        state_n   = GAP;
                        valid_n   = 1'b0;
                        gap_cnt_n = gap_lat;
                    end
                end
            end
            GAP: begin
                // Counter holds the number of low cycles still to go, including this one.
                gap_cnt_n = gap_cnt - GAP_W'(1);
                if (gap_cnt == GAP_W'(1)) begin
                    state_n = SEND;
                    valid_n = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state      <= IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            remaining  <= '0;
            xfer_count <= '0;
            gap_lat    <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            data_q     <= data_n;
            valid_q    <= valid_n;
            remaining  <= remaining_n;
            xfer_count <= count_n;
            gap_lat    <= gap_lat_n;
            gap_cnt    <= gap_cnt_n;
        end
    end

    assign stream.i_data  = data_q;
    assign stream.i_valid = valid_q;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
endmodule

// File: tb/tb_elastic_stream_src.sv
// tb/tb_elastic_stream_src.sv - scoreboard bench for elastic_stream_src
module tb_elastic_stream_src;
    logic        clk = 1'b0;
    logic        rstf = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_xfers = '0;
    logic [7:0]  gap_cycles = '0;
    logic [31:0] seed = '0;
    logic        busy, done;
    logic [15:0] xfer_count;

    elastic_stream_src_if #(.DATA_W(32)) s_if ();

    elastic_stream_src dut (
        .clk        (clk),
        .rstf       (rstf),
        .start      (start),
        .num_xfers  (num_xfers),
        .gap_cycles (gap_cycles),
        .seed       (seed),
        .stream     (s_if),
        .busy       (busy),
        .done       (done),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    int          exp_gap = 0;
    int          rdy_mode = 0;
    logic        rdy_force = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] x);
`ifdef ELASTIC_SRC_LFSR_EN
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
`else
        return x + 32'd1;
`endif
    endfunction

    function automatic logic [31:0] model_seed(input logic [31:0] s);
`ifdef ELASTIC_SRC_LFSR_EN
        return (s == 32'd0) ? 32'd1 : s;
`else
        return s;
`endif
    endfunction

    // Ready changes just after each rising edge, so a negedge sample is what the next edge sees.
    initial begin
        s_if.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) s_if.i_ready = ($urandom_range(0, 3) != 0);
            else               s_if.i_ready = rdy_force;
        end
    end

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data = '0;
    int          since_hs = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstf) begin
                prev_valid = 1'b0;
                since_hs   = -1;
            end else begin
                if (start && !busy) since_hs = -1;
                if (prev_valid && !prev_ready) begin
                    chk("hold_valid", s_if.i_valid, 1'b1);
                    chk("hold_data", s_if.i_data, prev_data);
                end
                if (s_if.i_valid) begin
                    if (since_hs >= 0) chk("gap_len", since_hs, exp_gap);
                    since_hs = -1;
                end else if (since_hs >= 0) begin
                    since_hs++;
                end
                if (s_if.i_valid && s_if.i_ready) begin
                    if (exp_q.size() == 0) chk("beat_expected", exp_q.size(), 1);
                    else                   chk("beat_data", s_if.i_data, exp_q.pop_front());
                    since_hs = 0;
                end
                prev_valid = s_if.i_valid;
                prev_ready = s_if.i_ready;
                prev_data  = s_if.i_data;
            end
        end
    end

    task automatic issue_start(input logic [31:0] s, input int n, input int g,
                               output logic [31:0] first);
        logic [31:0] d;
        d     = model_seed(s);
        first = d;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(d);
            d = model_next(d);
        end
        exp_gap    = g;
        start      = 1'b1;
        num_xfers  = 16'(n);
        gap_cycles = 8'(g);
        seed       = s;
        @(negedge clk);
        start      = 1'b0;
        num_xfers  = 16'($urandom);
        gap_cycles = 8'($urandom);
        seed       = $urandom;
    endtask

    task automatic burst(input logic [31:0] s, input int n, input int g, input int mode, input bit poke);
        logic [31:0] first;
        int          budget;
        rdy_mode  = mode;
        rdy_force = (mode == 2) ? 1'b0 : 1'b1;
        @(negedge clk);
        chk("idle_before_start", busy, 1'b0);
        issue_start(s, n, g, first);
        chk("start_to_valid", s_if.i_valid, (n != 0));
        if (n != 0) chk("first_data", s_if.i_data, first);
        if (mode == 2) begin
            repeat (2) @(negedge clk);
            chk("bp_data_held", s_if.i_data, first);
            rdy_force = 1'b1;
        end
        if (poke) begin
            start     = 1'b1;
            num_xfers = 16'd7;
            seed      = 32'hDEAD0000;
            @(negedge clk);
            start = 1'b0;
        end
        budget = 0;
        while (!done && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        chk("done_seen", done, 1'b1);
        if (n == 0) chk("zero_len_done_latency", budget, 0);
        chk("xfer_count", xfer_count, n);
        chk("queue_drained", exp_q.size(), 0);
        start     = 1'b1;
        num_xfers = 16'd5;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        chk("count_holds", xfer_count, n);
        chk("valid_idle", s_if.i_valid, 1'b0);
    endtask

    task automatic reset_mid;
        logic [31:0] first;
        int          budget;
        rdy_mode  = 0;
        rdy_force = 1'b1;
        @(negedge clk);
        issue_start(32'h20, 8, 0, first);
        budget = 0;
        while (exp_q.size() > 6 && budget < 100) begin
            @(negedge clk);
            #1;
            budget++;
        end
        chk("reset_reach_two_beats", exp_q.size(), 6);
        @(posedge clk);
        #2;
        chk("count_before_reset", xfer_count, 2);
        rstf = 1'b0;
        #1;
        chk("reset_async_valid", s_if.i_valid, 1'b0);
        chk("reset_async_count", xfer_count, 0);
        chk("reset_async_busy", busy, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rstf = 1'b1;
        burst(32'h5, 3, 0, 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", s_if.i_valid, 1'b0);
        chk("rst_data", s_if.i_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", xfer_count, 0);
        rstf = 1'b1;

        burst(32'h10, 4, 0, 0, 1'b0);
        burst(32'h0, 3, 2, 0, 1'b0);
        burst(32'h10, 2, 0, 2, 1'b0);
        burst(32'h0, 0, 0, 0, 1'b0);
        burst(32'hFFFF_FFFF, 2, 0, 0, 1'b0);
        reset_mid();
`ifdef ELASTIC_SRC_LFSR_EN
        burst(32'h1, 3, 0, 0, 1'b0);
        burst(32'h0, 2, 0, 0, 1'b0);
`endif
        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 7);
            burst($urandom, n, $urandom_range(0, 3), 1, (n >= 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
